uart_cmd_rx: RTL
================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter PULSE_CYCLES, default 16, clock cycles control is held high per accepted command.
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 number  output  5  command index presented to the downstream toggle decoder.
REQ-008 control  output  1  command strobe; the downstream decoder acts on its falling edge.
REQ-009 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 cmd_error  output  1  one-cycle pulse: byte outside the legal command set.
REQ-011 overrun  output  1  one-cycle pulse: byte dropped because the holding buffer was full.
REQ-012 busy  output  1  high while a frame is being received or a strobe is in progress.

Function
REQ-013 uart_rx SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-014 Oversampling tick SHALL occur every round(CLK_HZ/(BAUD*16)) cycles (27 at defaults); the divider SHALL restart on start-bit detection.
REQ-015 RX FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a synchronized falling edge of uart_rx.
REQ-017 START: after 8 ticks, re-sample the line; low -> DATA, high -> IDLE (glitch rejected, no flag).
REQ-018 DATA: sample every 16 ticks, 8 bits LSB first; after bit 7 -> STOP.
REQ-019 STOP: sample after 16 ticks; high -> byte valid; low -> frame_error pulse and byte discarded; either way -> IDLE.
REQ-020 Legal bytes: 0x00-0x15 map to number = byte[4:0]; 0xFF maps to number = 5'b11111 (reset-all); any other value -> cmd_error pulse, byte discarded.
REQ-021 Strobe FSM states: S_IDLE, S_HIGH, S_LOW.
REQ-022 S_IDLE with a legal command pending: load number, and on the next cycle raise control -> S_HIGH.
REQ-023 S_HIGH: control high for exactly PULSE_CYCLES cycles, then low -> S_LOW.
REQ-024 S_LOW: control low, number held unchanged for 2 cycles after the falling edge, then -> S_IDLE.
REQ-025 number SHALL change only in S_IDLE and SHALL otherwise hold its last value indefinitely.
REQ-026 One-entry holding buffer: a legal byte that completes while the strobe FSM is busy SHALL be stored and issued on return to S_IDLE.
REQ-027 Legal byte completing while the buffer is full -> overrun pulse, new byte dropped, buffered byte kept.
REQ-028 A byte completing in the same cycle the strobe FSM enters S_IDLE SHALL be issued directly, with no overrun.
REQ-029 Reception SHALL continue in parallel with strobe generation.
REQ-030 busy = (RX state != IDLE) OR (strobe state != S_IDLE) OR buffer full.

Reset
REQ-031 On reset_n low at a clock edge: RX FSM IDLE, strobe FSM S_IDLE, buffer empty, divider cleared.
REQ-032 Reset values: number 5'b11111, control 0, frame_error 0, cmd_error 0, overrun 0, busy 0.
REQ-033 Reset mid-frame or mid-strobe SHALL abort immediately; control SHALL drop without a pending command reissue.

Structure
REQ-034 Package uart_cmd_pkg SHALL hold the FSM state encodings, OVERSAMPLE=16, CMD_MAX=5'd21, and CMD_RESET_ALL=8'hFF.
REQ-035 Sub-module baud_tick SHALL generate the oversampling tick (parameters CLK_HZ and BAUD; inputs clock, reset_n, restart; output tick).

Verification
REQ-036 Send 0x03 at 115200 -> number=3, control high 16 cycles then low, and no error flags.
REQ-037 Send 0x15 then 0xFF back-to-back -> two strobes in order, with number 21 then 31.
REQ-038 Send 0x40 -> one cmd_error pulse, control stays 0, number unchanged.
REQ-039 Send 0x05 with stop bit forced low -> one frame_error pulse, and no strobe.
REQ-040 Set PULSE_CYCLES=20000 and send 0x01, 0x02, 0x03 -> 0x01 issued, 0x02 buffered then issued, 0x03 overrun pulse.
REQ-041 Pulse uart_rx low for 100 cycles -> no flags, RX returns to IDLE; assert reset_n low during S_HIGH -> control=0 and number=31 on the next cycle.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and command helpers for the UART command receiver.
package uart_cmd_pkg;

   localparam int         OVERSAMPLE    = 16;
   localparam logic [4:0] CMD_MAX       = 5'd21;
   localparam logic [7:0] CMD_RESET_ALL = 8'hFF;
   localparam logic [4:0] NUM_RESET_ALL = 5'b11111;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW}   strb_state_t;

   // Rounded clock cycles per oversampling tick.
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
   endfunction

   function automatic logic cmd_legal(input logic [7:0] b);
      return (b <= {3'b000, CMD_MAX}) || (b == CMD_RESET_ALL);
   endfunction

   // 0xFF is the reset-all command; every other legal byte carries its index in the low bits.
   function automatic logic [4:0] cmd_number(input logic [7:0] b);
      return (b == CMD_RESET_ALL) ? NUM_RESET_ALL : b[4:0];
   endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Serial input and command/status outputs of the UART command receiver.
interface uart_cmd_rx_if;
   logic       uart_rx;
   logic [4:0] number;
   logic       control;
   logic       frame_error;
   logic       cmd_error;
   logic       overrun;
   logic       busy;

   modport master (output uart_rx,
                   input  number, control, frame_error, cmd_error, overrun, busy);
   modport slave  (input  uart_rx,
                   output number, control, frame_error, cmd_error, overrun, busy);
endinterface

// File: rtl/uart_cmd_rx_baud_tick.sv
// Oversampling tick generator; restart realigns the divider to a start-bit edge.
module baud_tick
   import uart_cmd_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic clock,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int DIV = (baud_div(CLK_HZ, BAUD) < 1) ? 1 : baud_div(CLK_HZ, BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Free-running divider, one registered tick per DIV cycles.
   always_ff @(posedge clock) begin
      if (!reset_n || restart) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
         tick  <= 1'b1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver: decodes command bytes and issues one control strobe per
// legal command, with a one-entry holding buffer while a strobe is in progress.
module uart_cmd_rx
   import uart_cmd_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int PULSE_CYCLES = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   uart_cmd_rx_if.slave cmd
);

   localparam int CNT_W = (PULSE_CYCLES < 2) ? 2 : $clog2(PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] PCNT_END = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] PCNT_ONE = CNT_W'(1);
   localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] TICK_FULL = 4'(OVERSAMPLE - 1);

   // synchronizer and edge detect
   logic r_rx_meta, r_rx_sync, r_rx_prev;
   logic w_rx_fall, w_restart, w_tick;

   // receive path
   rx_state_t  r_rx_state;
   logic [3:0] r_tick_cnt;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic       r_frame_err, r_cmd_err, r_cmd_vld;
   logic [4:0] r_cmd_num;

   // strobe path
   strb_state_t      r_st;
   logic [CNT_W-1:0] r_pcnt;
   logic [4:0]       r_number;
   logic             r_control, r_overrun;
   logic             r_buf_full;
   logic [4:0]       r_buf_num;
   logic             w_pending;
   logic [4:0]       w_issue_num;

   assign w_rx_fall   = r_rx_prev & ~r_rx_sync;
   assign w_restart   = (r_rx_state == IDLE) & w_rx_fall;
   assign w_pending   = r_buf_full | r_cmd_vld;
   assign w_issue_num = r_buf_full ? r_buf_num : r_cmd_num;

   baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .restart (w_restart),
      .tick    (w_tick)
   );

   // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= cmd.uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Receive FSM: mid-bit sampling, stop-bit check and command classification.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rx_state  <= IDLE;
         r_tick_cnt  <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_cmd_vld   <= 1'b0;
         r_cmd_num   <= '0;
      end else begin
         r_frame_err <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_cmd_vld   <= 1'b0;
         case (r_rx_state)
            IDLE: if (w_rx_fall) begin
               r_rx_state <= START;
               r_tick_cnt <= '0;
            end
            // a start bit that is high again at its midpoint was only a glitch
            START: if (w_tick) begin
               if (r_tick_cnt == TICK_HALF) begin
                  r_tick_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_rx_state <= r_rx_sync ? IDLE : DATA;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
               end
            end
            DATA: if (w_tick) begin
               if (r_tick_cnt == TICK_FULL) begin
                  r_tick_cnt <= '0;
                  r_shift    <= {r_rx_sync, r_shift[7:1]};
                  r_bit_idx  <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_rx_state <= STOP;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
               end
            end
            STOP: if (w_tick) begin
               if (r_tick_cnt == TICK_FULL) begin
                  r_tick_cnt <= '0;
                  r_rx_state <= IDLE;
                  if (!r_rx_sync) begin
                     r_frame_err <= 1'b1;
                  end else if (cmd_legal(r_shift)) begin
                     r_cmd_vld <= 1'b1;
                     r_cmd_num <= cmd_number(r_shift);
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end else begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
               end
            end
            default: r_rx_state <= IDLE;
         endcase
      end
   end

   // Strobe FSM and holding buffer: number settles a cycle before control rises and is
   // held through the low phase so the decoder sees a stable index on the falling edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_st       <= S_IDLE;
         r_pcnt     <= '0;
         r_number   <= NUM_RESET_ALL;
         r_control  <= 1'b0;
         r_overrun  <= 1'b0;
         r_buf_full <= 1'b0;
         r_buf_num  <= '0;
      end else begin
         r_overrun <= 1'b0;
         case (r_st)
            S_IDLE: if (w_pending) begin
               r_number <= w_issue_num;
               r_pcnt   <= '0;
               r_st     <= S_HIGH;
            end
            S_HIGH: begin
               if (r_pcnt == PCNT_END) begin
                  r_control <= 1'b0;
                  r_pcnt    <= '0;
                  r_st      <= S_LOW;
               end else begin
                  r_control <= 1'b1;
                  r_pcnt    <= r_pcnt + PCNT_ONE;
               end
            end
            S_LOW: begin
               if (r_pcnt == PCNT_ONE) begin
                  r_pcnt <= '0;
                  r_st   <= S_IDLE;
               end else begin
                  r_pcnt <= r_pcnt + PCNT_ONE;
               end
            end
            default: begin
               r_control <= 1'b0;
               r_st      <= S_IDLE;
            end
         endcase

         // In S_IDLE the buffered command goes out first and a new arrival takes its slot;
         // only a busy strobe with a full buffer drops a byte.
         if (r_cmd_vld) begin
            if (r_st == S_IDLE) begin
               if (r_buf_full) r_buf_num <= r_cmd_num;
            end else if (!r_buf_full) begin
               r_buf_full <= 1'b1;
               r_buf_num  <= r_cmd_num;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if ((r_st == S_IDLE) && r_buf_full) begin
            r_buf_full <= 1'b0;
         end
      end
   end

   assign cmd.number      = r_number;
   assign cmd.control     = r_control;
   assign cmd.frame_error = r_frame_err;
   assign cmd.cmd_error   = r_cmd_err;
   assign cmd.overrun     = r_overrun;
   assign cmd.busy        = (r_rx_state != IDLE) || (r_st != S_IDLE) || r_buf_full;

endmodule
